// File: rtl/comparador_serie_ctrl_if.sv
// ---------------------------------------------------------------------------
// comparador_serie_ctrl_if
// Operand/result bus for the serial magnitude comparator controller.
//
// Handshake rule (both channels): a transfer happens at a rising clk edge
// where valid and ready are both 1. A source keeps valid asserted and its
// payload stable until that transfer. A sink may raise or lower ready
// freely; ready never depends combinationally on valid.
//
// Signals
//   in_valid  / in_ready   : operand channel (a, b)
//   out_valid / out_ready  : result channel (mayor, menor, igual)
// Modports
//   master : operand producer / result consumer (testbench, upstream logic)
//   slave  : the comparator controller
// ---------------------------------------------------------------------------
interface comparador_serie_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic             mayor;
   logic             menor;
   logic             igual;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, mayor, menor, igual
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, mayor, menor, igual
   );
endinterface

// File: rtl/comparador_serie_ctrl.sv
// ---------------------------------------------------------------------------
// comparador_serie_ctrl
// Sequencer around one registered MSB-first magnitude comparator cell. The
// operands are captured on acceptance and fed to the cell one bit pair per
// clock, replacing a WIDTH-cell combinational chain.
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   rst_n        : synchronous active-low reset
//   bus          : comparador_serie_ctrl_if.slave (operand in, result out)
//   busy         : comparison in progress (state RUN)
//   o_state_dbg  : current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Optional feature: define COMPARADOR_SALIDA_TEMPRANA_EN to finish as soon as
// the cell leaves the "equal so far" state instead of always walking all
// WIDTH bits. Equal operands take WIDTH cycles either way.
//
// Cell state (m,n): 11 equal so far, 10 A>B, 01 A<B, 00 unreachable (no flag).
// ---------------------------------------------------------------------------
module comparador_serie_ctrl #(
   parameter int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   comparador_serie_ctrl_if.slave bus,
   output logic                   busy,
   output logic [1:0]             o_state_dbg
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [CNT_W-1:0]   r_idx;
   logic               r_m;
   logic               r_n;
   logic               r_mayor;
   logic               r_menor;
   logic               r_igual;

   logic               w_bit_a;
   logic               w_bit_b;
   logic               w_m_nxt;
   logic               w_n_nxt;

   // Comparator cell applied to the current bit pair.
   assign w_bit_a = r_a[r_idx];
   assign w_bit_b = r_b[r_idx];
   assign w_m_nxt = ~r_n | (r_m & (w_bit_a | ~w_bit_b));
   assign w_n_nxt = ~r_m | (r_n & (~w_bit_a | w_bit_b));

   // Next-state and outputs.
   always_comb begin
      w_state_nxt  = r_state;
      bus.in_ready = 1'b0;
      bus.out_valid = 1'b0;
      busy         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            busy = 1'b1;
            if (r_idx == '0) w_state_nxt = ST_DONE;
`ifdef COMPARADOR_SALIDA_TEMPRANA_EN
            // The decision is sticky, so once it is made the rest of the
            // bits cannot change it.
            if (!(w_m_nxt && w_n_nxt)) w_state_nxt = ST_DONE;
`endif
         end
         ST_DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Datapath.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_idx   <= '0;
         r_m     <= 1'b1;
         r_n     <= 1'b1;
         r_mayor <= 1'b0;
         r_menor <= 1'b0;
         r_igual <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  r_a   <= bus.a;
                  r_b   <= bus.b;
                  r_m   <= 1'b1;
                  r_n   <= 1'b1;
                  r_idx <= CNT_W'(WIDTH - 1);
               end
            end
            ST_RUN: begin
               r_m <= w_m_nxt;
               r_n <= w_n_nxt;
               if (r_idx != '0) r_idx <= r_idx - 1'b1;
               // Flags come from the cell output of the last RUN edge so
               // they are valid in the same cycle out_valid rises.
               if (w_state_nxt == ST_DONE) begin
                  r_igual <= w_m_nxt & w_n_nxt;
                  r_mayor <= w_m_nxt & ~w_n_nxt;
                  r_menor <= ~w_m_nxt & w_n_nxt;
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  r_mayor <= 1'b0;
                  r_menor <= 1'b0;
                  r_igual <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.mayor = r_mayor;
   assign bus.menor = r_menor;
   assign bus.igual = r_igual;
   assign o_state_dbg = r_state;

endmodule

// File: tb/tb_comparador_serie_ctrl.sv
// ---------------------------------------------------------------------------
// tb_comparador_serie_ctrl
// Directed vector table plus hand-written sequences for reset during RUN,
// result hold/backpressure, and a back-to-back randomised run against a
// behavioural compare.
// ---------------------------------------------------------------------------
module tb_comparador_serie_ctrl;
   localparam int W = 8;

   logic       clk;
   logic       rst_n;
   logic       busy;
   logic [1:0] state_dbg;

   comparador_serie_ctrl_if #(.WIDTH(W)) bus ();

   comparador_serie_ctrl #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .busy        (busy),
      .o_state_dbg (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // expected-result models
   function automatic logic [2:0] exp_flags(input logic [W-1:0] a, input logic [W-1:0] b);
      // {mayor, menor, igual}
      if (a > b)      return 3'b100;
      else if (a < b) return 3'b010;
      else            return 3'b001;
   endfunction

   function automatic int exp_latency(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef COMPARADOR_SALIDA_TEMPRANA_EN
      for (int k = W - 1; k >= 0; k--)
         if (a[k] != b[k]) return W - k;
      return W;
`else
      return W;
`endif
   endfunction

   // driver: send one pair, measure latency, optionally release the result
   task automatic do_compare(input logic [W-1:0] a, input logic [W-1:0] b,
                             input bit release_now,
                             output logic [2:0] flags, output int lat);
      int guard;
      guard = 0;
      while (!bus.in_ready && guard < 40) begin
         @(posedge clk); #1; guard++;
      end
      if (!bus.in_ready) begin
         errors++; checks++;
         $display("FAIL in_ready_timeout: got 0 expected 1");
      end
      bus.a = a; bus.b = b; bus.in_valid = 1'b1;
      @(posedge clk); #1;                        // edge T0
      bus.in_valid = 1'b0;
      bus.a = W'($urandom); bus.b = W'($urandom); // operands must be internal copies
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      if (!bus.out_valid) begin
         errors++; checks++;
         $display("FAIL out_valid_timeout: got 0 expected 1");
      end
      flags = {bus.mayor, bus.menor, bus.igual};
      if (release_now) begin
         bus.out_ready = 1'b1;
         @(posedge clk); #1;
         bus.out_ready = 1'b0;
      end
   endtask

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [2:0]   flags;      // {mayor, menor, igual}
      int           lat_fixed;
      int           lat_early;
   } vec_t;

   vec_t vecs[10];
   logic [2:0] flags;
   int         lat;
   bit         seen_valid;

   initial begin
      vecs[0] = '{8'hA5, 8'hA5, 3'b001, 8, 8};
      vecs[1] = '{8'h80, 8'h7F, 3'b100, 8, 1};
      vecs[2] = '{8'h10, 8'h11, 3'b010, 8, 8};
      vecs[3] = '{8'h00, 8'hFF, 3'b010, 8, 1};
      vecs[4] = '{8'hFF, 8'h00, 3'b100, 8, 1};
      vecs[5] = '{8'h00, 8'h00, 3'b001, 8, 8};
      vecs[6] = '{8'hFF, 8'hFF, 3'b001, 8, 8};
      vecs[7] = '{8'h3C, 8'h34, 3'b100, 8, 5};
      vecs[8] = '{8'h01, 8'h00, 3'b100, 8, 8};
      vecs[9] = '{8'h7F, 8'h80, 3'b010, 8, 1};

      bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      // reset state
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_in_ready", bus.in_ready, 1'b1);
      check("rst_flags", {bus.mayor, bus.menor, bus.igual}, 3'b000);
      check("rst_state", state_dbg, 2'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // table of directed vectors
      for (int i = 0; i < 10; i++) begin
         do_compare(vecs[i].a, vecs[i].b, 1'b1, flags, lat);
         check($sformatf("vec%0d_flags", i), flags, vecs[i].flags);
`ifdef COMPARADOR_SALIDA_TEMPRANA_EN
         check($sformatf("vec%0d_lat", i), lat, vecs[i].lat_early);
`else
         check($sformatf("vec%0d_lat", i), lat, vecs[i].lat_fixed);
`endif
         check($sformatf("vec%0d_cleared", i), {bus.out_valid, bus.mayor, bus.menor, bus.igual}, 4'b0000);
      end

      // reset in the middle of RUN
      bus.a = 8'h80; bus.b = 8'h00; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("midrun_busy_before", busy, 1'b1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("midrun_out_valid", bus.out_valid, 1'b0);
      check("midrun_busy", busy, 1'b0);
      check("midrun_in_ready", bus.in_ready, 1'b1);
      check("midrun_flags", {bus.mayor, bus.menor, bus.igual}, 3'b000);
      rst_n = 1'b1;
      seen_valid = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         if (bus.out_valid) seen_valid = 1'b1;
      end
      check("midrun_no_result", seen_valid, 1'b0);

      // hold result under backpressure; in_valid ignored while in DONE
      do_compare(8'h80, 8'h7F, 1'b0, flags, lat);
      check("hold_first_flags", flags, 3'b100);
      bus.in_valid = 1'b1; bus.a = 8'h00; bus.b = 8'hFF;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check($sformatf("hold%0d_valid", c), bus.out_valid, 1'b1);
         check($sformatf("hold%0d_flags", c), {bus.mayor, bus.menor, bus.igual}, 3'b100);
         check($sformatf("hold%0d_in_ready", c), bus.in_ready, 1'b0);
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check("release_state", state_dbg, 2'd0);
      check("release_in_ready", bus.in_ready, 1'b1);
      check("release_cleared", {bus.out_valid, bus.mayor, bus.menor, bus.igual}, 4'b0000);

      // randomised back-to-back run against the behavioural compare
      for (int i = 0; i < 1000; i++) begin
         logic [W-1:0] ra, rb;
         ra = W'($urandom_range(0, 255));
         rb = (i % 4 == 0) ? ra : W'($urandom_range(0, 255));
         do_compare(ra, rb, 1'b1, flags, lat);
         check($sformatf("rnd%0d_flags", i), flags, exp_flags(ra, rb));
         check($sformatf("rnd%0d_lat", i), lat, exp_latency(ra, rb));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // hard stop in case a wait ever escapes its bound
   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
